// File: rtl/uart_cmd_frame_parser_if.sv
// Byte-stream and register-bus signals shared by the UART command frame parser
// and its neighbours; master is the parser side.
interface uart_cmd_frame_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        frame_err;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata, bus_rvalid,
        output tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, frame_err, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata, bus_rvalid,
        input  tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_re, frame_err, busy
    );
endinterface

// File: rtl/uart_cmd_frame_parser.sv
// Decodes write/read command frames from the UART RX byte stream, issues single-cycle
// register-bus accesses and streams 32-bit read data back to UART TX, LSB first.
module uart_cmd_frame_parser #(
    parameter int          BYTE_TIMEOUT = 1_000_000,
    parameter int          RD_TIMEOUT   = 255,
    parameter logic [7:0]  ERR_BYTE     = 8'hEE,
    parameter logic [31:0] RD_FAIL_WORD = 32'hDEAD_DEAD
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_cmd_frame_parser_if.master     bus_if
);

    localparam logic [7:0]  CMD_WRITE  = 8'h01;
    localparam logic [7:0]  CMD_READ   = 8'h02;
    localparam logic [31:0] BYTE_LIMIT = 32'(BYTE_TIMEOUT - 1);
    localparam logic [31:0] RD_LIMIT   = 32'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WR, RD_REQ, RD_WAIT, TX, ERR
    } state_t;

    state_t      state_reg;
    logic        is_write_reg;
    logic [1:0]  widx_reg;
    logic [1:0]  tx_idx_reg;
    logic [31:0] timer_reg;
    logic [31:0] resp_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_valid_reg;
    logic [7:0]  bus_addr_reg;
    logic [31:0] bus_wdata_reg;
    logic        bus_we_reg;
    logic        bus_re_reg;
    logic        frame_err_reg;
    logic        busy_reg;

    assign bus_if.tx_data   = tx_data_reg;
    assign bus_if.tx_valid  = tx_valid_reg;
    assign bus_if.bus_addr  = bus_addr_reg;
    assign bus_if.bus_wdata = bus_wdata_reg;
    assign bus_if.bus_we    = bus_we_reg;
    assign bus_if.bus_re    = bus_re_reg;
    assign bus_if.frame_err = frame_err_reg;
    assign bus_if.busy      = busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            is_write_reg  <= 1'b0;
            widx_reg      <= 2'd0;
            tx_idx_reg    <= 2'd0;
            timer_reg     <= 32'd0;
            resp_reg      <= 32'd0;
            tx_data_reg   <= 8'd0;
            tx_valid_reg  <= 1'b0;
            bus_addr_reg  <= 8'd0;
            bus_wdata_reg <= 32'd0;
            bus_we_reg    <= 1'b0;
            bus_re_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Strobes are one cycle wide unless a transition below re-arms them.
            bus_we_reg    <= 1'b0;
            bus_re_reg    <= 1'b0;
            frame_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus_if.rx_valid) begin
                        timer_reg <= 32'd0;
                        busy_reg  <= 1'b1;
                        if (bus_if.rx_data == CMD_WRITE || bus_if.rx_data == CMD_READ) begin
                            is_write_reg <= (bus_if.rx_data == CMD_WRITE);
                            state_reg    <= ADDR;
                        end else begin
                            frame_err_reg <= 1'b1;
                            tx_data_reg   <= ERR_BYTE;
                            tx_valid_reg  <= 1'b1;
                            state_reg     <= ERR;
                        end
                    end
                end

                ADDR: begin
                    if (bus_if.rx_valid) begin
                        bus_addr_reg <= bus_if.rx_data;
                        timer_reg    <= 32'd0;
                        widx_reg     <= 2'd0;
                        if (is_write_reg) begin
                            state_reg <= WDATA;
                        end else begin
                            bus_re_reg <= 1'b1;
                            state_reg  <= RD_REQ;
                        end
                    end else if (timer_reg == BYTE_LIMIT) begin
                        frame_err_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end

                WDATA: begin
                    if (bus_if.rx_valid) begin
                        bus_wdata_reg[{widx_reg, 3'b000} +: 8] <= bus_if.rx_data;
                        widx_reg  <= widx_reg + 2'd1;
                        timer_reg <= 32'd0;
                        if (widx_reg == 2'd3) begin
                            bus_we_reg <= 1'b1;
                            state_reg  <= WR;
                        end
                    end else if (timer_reg == BYTE_LIMIT) begin
                        frame_err_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end

                WR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                RD_REQ: begin
                    // Read data only counts from RD_WAIT onwards, so a strobe here is ignored.
                    timer_reg <= 32'd0;
                    state_reg <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (bus_if.bus_rvalid) begin
                        resp_reg     <= bus_if.bus_rdata;
                        tx_data_reg  <= bus_if.bus_rdata[7:0];
                        tx_valid_reg <= 1'b1;
                        tx_idx_reg   <= 2'd0;
                        state_reg    <= TX;
                    end else if (timer_reg == RD_LIMIT) begin
                        resp_reg      <= RD_FAIL_WORD;
                        tx_data_reg   <= RD_FAIL_WORD[7:0];
                        tx_valid_reg  <= 1'b1;
                        tx_idx_reg    <= 2'd0;
                        frame_err_reg <= 1'b1;
                        state_reg     <= TX;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end

                TX: begin
                    if (bus_if.tx_ready) begin
                        if (tx_idx_reg == 2'd3) begin
                            tx_valid_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            state_reg    <= IDLE;
                        end else begin
                            resp_reg    <= {8'd0, resp_reg[31:8]};
                            tx_data_reg <= resp_reg[15:8];
                            tx_idx_reg  <= tx_idx_reg + 2'd1;
                        end
                    end
                end

                ERR: begin
                    if (bus_if.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench for uart_cmd_frame_parser: write/read frames, TX backpressure,
// error paths, inter-byte timeout and mid-operation reset.
module tb_uart_cmd_frame_parser;

    localparam int BT    = 100;
    localparam int RD_TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_frame_parser_if ifc ();

    uart_cmd_frame_parser #(.BYTE_TIMEOUT(BT), .RD_TIMEOUT(RD_TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (ifc)
    );

    int checks = 0;
    int passed = 0;

    int          we_cnt = 0;
    int          re_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    logic [7:0]  last_waddr = 8'd0;
    logic [31:0] last_wdata = 32'd0;

    always @(posedge clk) begin
        if (ifc.bus_we === 1'b1) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= ifc.bus_addr;
            last_wdata <= ifc.bus_wdata;
        end
        if (ifc.bus_re === 1'b1)    re_cnt   <= re_cnt + 1;
        if (ifc.frame_err === 1'b1) err_cnt  <= err_cnt + 1;
        if (ifc.bus_we === 1'b1 && ifc.bus_re === 1'b1) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    task automatic wait_re(output int cyc);
        cyc = -1;
        for (int i = 0; i < 20 && cyc < 0; i++) begin
            if (ifc.bus_re === 1'b1) cyc = i;
            else @(negedge clk);
        end
    endtask

    // Supplies read data three cycles after the bus_re cycle.
    task automatic respond(input logic [31:0] data);
        repeat (3) @(negedge clk);
        ifc.bus_rdata  = data;
        ifc.bus_rvalid = 1'b1;
        @(negedge clk);
        ifc.bus_rvalid = 1'b0;
    endtask

    task automatic collect_tx(input int n, input bit throttle, input int budget,
                              output logic [31:0] word, output int got,
                              output int unstable, output int first_wait);
        bit         prev_stall;
        logic [7:0] prev_data;
        word = 32'd0; got = 0; unstable = 0; first_wait = -1;
        prev_stall = 1'b0; prev_data = 8'd0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (prev_stall && (ifc.tx_valid !== 1'b1 || ifc.tx_data !== prev_data)) unstable++;
            if (ifc.tx_valid === 1'b1 && first_wait < 0) first_wait = c;
            ifc.tx_ready = throttle ? (c % 3 == 2) : 1'b1;
            if (ifc.tx_valid === 1'b1 && ifc.tx_ready) begin
                word[8*got +: 8] = ifc.tx_data;
                got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = (ifc.tx_valid === 1'b1);
                prev_data  = ifc.tx_data;
            end
            @(negedge clk);
        end
        ifc.tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (ifc.busy !== 1'b0 || ifc.tx_valid !== 1'b0 || ifc.frame_err !== 1'b0)
            $display("FAIL reset_ctrl: got busy=%b tx_valid=%b frame_err=%b required 0/0/0", ifc.busy, ifc.tx_valid, ifc.frame_err); else passed++;
        checks++; if (ifc.bus_we !== 1'b0 || ifc.bus_re !== 1'b0)
            $display("FAIL reset_strobes: got we=%b re=%b required 0/0", ifc.bus_we, ifc.bus_re); else passed++;
        checks++; if (ifc.tx_data !== 8'd0 || ifc.bus_addr !== 8'd0 || ifc.bus_wdata !== 32'd0)
            $display("FAIL reset_data: got tx_data=%h addr=%h wdata=%h required 0", ifc.tx_data, ifc.bus_addr, ifc.bus_wdata); else passed++;
    endtask

    task automatic test_write;
        int we0, e0;
        we0 = we_cnt; e0 = err_cnt;
        send_byte(8'h01); send_byte(8'h10); send_byte(8'hBE);
        send_byte(8'hBA); send_byte(8'hFE); send_byte(8'hCA);
        checks++; if (ifc.bus_we !== 1'b1) $display("FAIL write_we_latency: got %b required 1", ifc.bus_we); else passed++;
        checks++; if (ifc.bus_addr !== 8'h10) $display("FAIL write_addr: got %h required 10", ifc.bus_addr); else passed++;
        checks++; if (ifc.bus_wdata !== 32'hCAFEBABE) $display("FAIL write_wdata: got %h required cafebabe", ifc.bus_wdata); else passed++;
        @(negedge clk);
        checks++; if (ifc.bus_we !== 1'b0 || ifc.busy !== 1'b0 || ifc.tx_valid !== 1'b0)
            $display("FAIL write_after: got we=%b busy=%b tx_valid=%b required 0/0/0", ifc.bus_we, ifc.busy, ifc.tx_valid); else passed++;
        checks++; if (we_cnt !== we0 + 1) $display("FAIL write_we_count: got %0d required %0d", we_cnt, we0 + 1); else passed++;
        checks++; if (err_cnt !== e0) $display("FAIL write_frame_err: got %0d required %0d", err_cnt, e0); else passed++;
    endtask

    task automatic test_read;
        int re0, cyc, got, unstable, fw;
        logic [31:0] word;
        re0 = re_cnt;
        send_byte(8'h02); send_byte(8'h10);
        wait_re(cyc);
        checks++; if (cyc !== 0) $display("FAIL read_re_latency: got %0d required 0", cyc); else passed++;
        checks++; if (ifc.bus_addr !== 8'h10) $display("FAIL read_addr: got %h required 10", ifc.bus_addr); else passed++;
        respond(32'hCAFEBABE);
        collect_tx(4, 1'b0, 20, word, got, unstable, fw);
        checks++; if (got !== 4 || word !== 32'hCAFEBABE)
            $display("FAIL read_tx_bytes: got %0d bytes word %h required 4 bytes cafebabe", got, word); else passed++;
        checks++; if (fw !== 0) $display("FAIL read_tx_latency: got %0d required 0", fw); else passed++;
        checks++; if (ifc.busy !== 1'b0 || ifc.tx_valid !== 1'b0)
            $display("FAIL read_done: got busy=%b tx_valid=%b required 0/0", ifc.busy, ifc.tx_valid); else passed++;
        checks++; if (re_cnt !== re0 + 1) $display("FAIL read_re_count: got %0d required %0d", re_cnt, re0 + 1); else passed++;
    endtask

    task automatic test_backpressure;
        int re0, cyc, got, unstable, fw;
        logic [31:0] word;
        re0 = re_cnt;
        send_byte(8'h02); send_byte(8'h10);
        wait_re(cyc);
        // Strobe coinciding with bus_re must be ignored.
        ifc.bus_rdata = 32'h12345678; ifc.bus_rvalid = 1'b1;
        @(negedge clk);
        ifc.bus_rvalid = 1'b0;
        repeat (1) @(negedge clk);
        ifc.bus_rdata = 32'hCAFEBABE; ifc.bus_rvalid = 1'b1;
        @(negedge clk);
        ifc.bus_rvalid = 1'b0;
        collect_tx(4, 1'b1, 40, word, got, unstable, fw);
        checks++; if (got !== 4 || word !== 32'hCAFEBABE)
            $display("FAIL bp_tx_bytes: got %0d bytes word %h required 4 bytes cafebabe", got, word); else passed++;
        checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d unstable cycles required 0", unstable); else passed++;
        checks++; if (ifc.tx_valid !== 1'b0 || ifc.busy !== 1'b0)
            $display("FAIL bp_done: got tx_valid=%b busy=%b required 0/0", ifc.tx_valid, ifc.busy); else passed++;
        checks++; if (re_cnt !== re0 + 1) $display("FAIL bp_re_count: got %0d required %0d", re_cnt, re0 + 1); else passed++;
    endtask

    task automatic test_unknown_cmd;
        int we0, re0, e0, got, unstable, fw;
        logic [31:0] word;
        we0 = we_cnt; re0 = re_cnt; e0 = err_cnt;
        send_byte(8'h7F);
        checks++; if (ifc.frame_err !== 1'b1) $display("FAIL unk_frame_err: got %b required 1", ifc.frame_err); else passed++;
        checks++; if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'hEE)
            $display("FAIL unk_tx: got valid=%b data=%h required 1/ee", ifc.tx_valid, ifc.tx_data); else passed++;
        collect_tx(1, 1'b0, 10, word, got, unstable, fw);
        checks++; if (got !== 1 || word !== 32'h000000EE)
            $display("FAIL unk_tx_bytes: got %0d bytes word %h required 1 byte ee", got, word); else passed++;
        checks++; if (ifc.tx_valid !== 1'b0 || ifc.busy !== 1'b0)
            $display("FAIL unk_done: got tx_valid=%b busy=%b required 0/0", ifc.tx_valid, ifc.busy); else passed++;
        checks++; if (we_cnt !== we0 || re_cnt !== re0 || err_cnt !== e0 + 1)
            $display("FAIL unk_counts: got we=%0d re=%0d err=%0d required %0d/%0d/%0d", we_cnt, re_cnt, err_cnt, we0, re0, e0 + 1); else passed++;
    endtask

    task automatic test_read_timeout;
        int e0, cyc, got, unstable, fw;
        logic [31:0] word;
        e0 = err_cnt;
        send_byte(8'h02); send_byte(8'h30);
        wait_re(cyc);
        collect_tx(4, 1'b0, RD_TO + 20, word, got, unstable, fw);
        checks++; if (got !== 4 || word !== 32'hDEADDEAD)
            $display("FAIL rdto_tx_bytes: got %0d bytes word %h required 4 bytes deaddead", got, word); else passed++;
        checks++; if (fw < RD_TO || fw > RD_TO + 2)
            $display("FAIL rdto_latency: got %0d required %0d..%0d", fw, RD_TO, RD_TO + 2); else passed++;
        checks++; if (err_cnt !== e0 + 1) $display("FAIL rdto_frame_err: got %0d required %0d", err_cnt, e0 + 1); else passed++;
    endtask

    task automatic test_byte_timeout;
        int we0, e0;
        we0 = we_cnt; e0 = err_cnt;
        send_byte(8'h01); send_byte(8'h10); send_byte(8'hBE);
        repeat (BT - 1) @(negedge clk);
        checks++; if (ifc.busy !== 1'b1) $display("FAIL bto_early: got busy=%b required 1", ifc.busy); else passed++;
        @(negedge clk);
        checks++; if (ifc.frame_err !== 1'b1 || ifc.busy !== 1'b0)
            $display("FAIL bto_abort: got frame_err=%b busy=%b required 1/0", ifc.frame_err, ifc.busy); else passed++;
        send_byte(8'h01); send_byte(8'h20); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        checks++; if (last_waddr !== 8'h20 || last_wdata !== 32'h44332211)
            $display("FAIL bto_next_write: got addr=%h wdata=%h required 20/44332211", last_waddr, last_wdata); else passed++;
        checks++; if (we_cnt !== we0 + 1 || err_cnt !== e0 + 1)
            $display("FAIL bto_counts: got we=%0d err=%0d required %0d/%0d", we_cnt, err_cnt, we0 + 1, e0 + 1); else passed++;
    endtask

    task automatic test_reset_mid;
        int we0, cyc, got, unstable, fw;
        logic [31:0] word;
        we0 = we_cnt;
        send_byte(8'h01); send_byte(8'h40); send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ifc.busy !== 1'b0 || ifc.bus_wdata !== 32'd0 || ifc.bus_addr !== 8'd0)
            $display("FAIL rstw_outputs: got busy=%b wdata=%h addr=%h required 0", ifc.busy, ifc.bus_wdata, ifc.bus_addr); else passed++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (we_cnt !== we0) $display("FAIL rstw_no_we: got %0d required %0d", we_cnt, we0); else passed++;

        send_byte(8'h02); send_byte(8'h50);
        wait_re(cyc);
        respond(32'h89ABCDEF);
        collect_tx(1, 1'b0, 10, word, got, unstable, fw);
        checks++; if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'hCD)
            $display("FAIL rstt_byte1: got valid=%b data=%h required 1/cd", ifc.tx_valid, ifc.tx_data); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ifc.tx_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.tx_data !== 8'd0)
            $display("FAIL rstt_outputs: got valid=%b busy=%b data=%h required 0/0/00", ifc.tx_valid, ifc.busy, ifc.tx_data); else passed++;
        rst = 1'b0;
        @(negedge clk);

        send_byte(8'h02); send_byte(8'h55);
        wait_re(cyc);
        checks++; if (cyc !== 0 || ifc.bus_addr !== 8'h55)
            $display("FAIL rst_read_re: got cyc=%0d addr=%h required 0/55", cyc, ifc.bus_addr); else passed++;
        respond(32'h0BADF00D);
        collect_tx(4, 1'b0, 20, word, got, unstable, fw);
        checks++; if (got !== 4 || word !== 32'h0BADF00D)
            $display("FAIL rst_read_tx: got %0d bytes word %h required 4 bytes 0badf00d", got, word); else passed++;
    endtask

    initial begin
        ifc.rx_data = 8'd0; ifc.rx_valid = 1'b0; ifc.tx_ready = 1'b0;
        ifc.bus_rdata = 32'd0; ifc.bus_rvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_write;
        test_read;
        test_backpressure;
        test_unknown_cmd;
        test_read_timeout;
        test_byte_timeout;
        test_reset_mid;
        checks++; if (both_cnt !== 0) $display("FAIL we_re_overlap: got %0d required 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
